// File: rtl/tinyyolo_pkg.sv
// Shared types and constants for the TinyYOLO output path.
package tinyyolo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pack_state_e;

    localparam int OUT_DATA_W     = 64;
    localparam int OUT_FIFO_DEPTH = 16;

endpackage

// File: rtl/tinyyolo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on rd_data_o
// whenever empty_o is low. Pointers carry one extra wrap bit to tell full from empty.
module tinyyolo_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/tinyyolo_axis_out_packer.sv
// Buffers conv results into an AXI4-Stream master and frames a tile with tlast/done.
// Define TINYYOLO_OUT_PACKER_ERR_EN to add the sticky err_overrun output.
//
// state | meaning
// IDLE  | waiting for start, idle=1
// RUN   | accepting input words until cfg_beats have been written
// DRAIN | input closed, emptying the buffer onto the stream
// DONE  | single-cycle done pulse
module tinyyolo_axis_out_packer
    import tinyyolo_pkg::*;
#(
    parameter int DATA_W     = OUT_DATA_W,
    parameter int FIFO_DEPTH = OUT_FIFO_DEPTH
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                start,
    input  logic [31:0]         cfg_beats,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                m_axis_output_tvalid,
    input  logic                m_axis_output_tready,
    output logic [DATA_W-1:0]   m_axis_output_tdata,
    output logic [DATA_W/8-1:0] m_axis_output_tkeep,
    output logic                m_axis_output_tlast,
    output logic                done,
`ifdef TINYYOLO_OUT_PACKER_ERR_EN
    output logic                err_overrun,
`endif
    output logic                idle
);

    pack_state_e state_q, state_d;
    logic [31:0] beats_q, beats_d;
    logic [31:0] in_cnt_q, in_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic        fifo_full, fifo_empty;
    logic        push, pop, last_beat;

    // in_ready depends only on registered state, never on tready
    assign in_ready  = (state_q == RUN) && !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = m_axis_output_tvalid && m_axis_output_tready;
    assign last_beat = (out_cnt_q == beats_q - 32'd1);

    assign m_axis_output_tvalid = !fifo_empty;
    assign m_axis_output_tlast  = m_axis_output_tvalid && last_beat;
    assign m_axis_output_tkeep  = '1;
    assign done                 = (state_q == DONE);
    assign idle                 = (state_q == IDLE);

    tinyyolo_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (ap_clk),
        .rst_n_i   (ap_rst_n),
        .wr_en_i   (push),
        .wr_data_i (in_data),
        .rd_en_i   (m_axis_output_tready),
        .rd_data_o (m_axis_output_tdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (push) in_cnt_d  = in_cnt_q + 32'd1;
        if (pop)  out_cnt_d = out_cnt_q + 32'd1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    beats_d   = cfg_beats;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (cfg_beats == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push && (in_cnt_q + 32'd1 == beats_q)) state_d = DRAIN;
            end
            DRAIN: begin
                // the tlast handshake empties the buffer, since every word is already in
                if (pop && last_beat) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef TINYYOLO_OUT_PACKER_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start) begin
            err_d = 1'b0;
        end else if (in_valid && ((state_q == DRAIN) || (state_q == DONE))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign err_overrun = err_q;
`endif

endmodule
